// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and FSM state type for the bus generator/arbiter
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
module rr_arbiter #(
    parameter int drvrs = 4,
    parameter int IW    = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input  logic [drvrs-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [drvrs-1:0] grant_oh,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_vld
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = drvrs; i >= 1; i--) begin
            cand = IW'((int'(last_grant) + i) % drvrs);
            if (req[cand]) begin
                grant_oh       = '0;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
                grant_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// rtl/bs_gnrtr_n_rbtr.sv - shared-bus generator: round-robin pop from drivers, unicast/broadcast push
module bs_gnrtr_n_rbtr
    import bus_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_DEF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [bits-1:0][drvrs-1:0]                 pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [bits-1:0][drvrs-1:0]                 pop,
    output logic [bits-1:0][drvrs-1:0]                 push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_push
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    state_t               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;

    logic [drvrs-1:0]     arb_oh;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;
    logic [pckg_sz-1:0]   head;
    logic [ID_W-1:0]      head_id;

    rr_arbiter #(.drvrs(drvrs), .IW(IW)) u_rr_arbiter (
        .req        (pndng[0]),
        .last_grant (last_q),
        .grant_oh   (arb_oh),
        .grant_idx  (arb_idx),
        .grant_vld  (arb_vld)
    );

    assign head    = D_pop[0][grant_q];
    assign head_id = head[pckg_sz-1 -: ID_W];

    // push strobes are computed one cycle early so they leave a register in PUSH.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        pkt_d   = pkt_q;
        pop_d   = '0;
        push_d  = '0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = POP;
                    grant_d = arb_idx;
                    last_d  = arb_idx;
                    pop_d   = arb_oh;
                end
            end
            POP: begin
                state_d = PUSH;
                pkt_d   = head;
                if (head_id == broadcast) begin
                    push_d          = '1;
                    push_d[grant_q] = 1'b0;
                end else if (head_id < ID_W'(drvrs)) begin
                    push_d[head_id[IW-1:0]] = 1'b1;
                end
            end
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(drvrs - 1);
            pkt_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
        end
    end

    assign pop[0]    = pop_q;
    assign push[0]   = push_q;
    assign D_push[0] = {drvrs{pkt_q}};

    for (genvar b = 1; b < bits; b++) begin : g_idle_inst
        assign pop[b]    = '0;
        assign push[b]   = '0;
        assign D_push[b] = '0;
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb/tb_bs_gnrtr_n_rbtr.sv - directed vector bench for bs_gnrtr_n_rbtr with drvrs=8, pckg_sz=16
module tb_bs_gnrtr_n_rbtr;

    localparam int DRV = 8;
    localparam int PW  = 16;

    logic                        clk;
    logic                        reset;
    logic [0:0][DRV-1:0]         pndng;
    logic [0:0][DRV-1:0][PW-1:0] D_pop;
    logic [0:0][DRV-1:0]         pop;
    logic [0:0][DRV-1:0]         push;
    logic [0:0][DRV-1:0][PW-1:0] D_push;

    int checks;
    int errors;

    typedef struct {
        int         src;
        logic [15:0] data;
        logic [7:0]  exp_push;
    } vec_t;

    vec_t vecs[8];

    bs_gnrtr_n_rbtr #(
        .bits      (1),
        .drvrs     (DRV),
        .pckg_sz   (PW),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        pndng = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        pndng  = '0;
        D_pop  = '0;

        vecs[0] = '{2, 16'h05AB, 8'h20};
        vecs[1] = '{0, 16'hFF12, 8'hFE};
        vecs[2] = '{3, 16'h0A34, 8'h00};
        vecs[3] = '{5, 16'h0577, 8'h20};
        vecs[4] = '{7, 16'h07C3, 8'h80};
        vecs[5] = '{6, 16'h08EE, 8'h00};
        vecs[6] = '{7, 16'hFF00, 8'h7F};
        vecs[7] = '{4, 16'h0000, 8'h01};

        @(negedge clk);
        chk("reset_pop", 128'(pop), 128'd0);
        chk("reset_push", 128'(push), 128'd0);
        chk("reset_dpush", 128'(D_push), 128'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_pop", 128'(pop), 128'd0);

        for (int v = 0; v < 8; v++) begin
            pndng[0][vecs[v].src] = 1'b1;
            D_pop[0][vecs[v].src] = vecs[v].data;
            @(negedge clk);
            chk($sformatf("v%0d_pop", v), 128'(pop), 128'(8'(1) << vecs[v].src));
            chk($sformatf("v%0d_push_in_pop", v), 128'(push), 128'd0);
            pndng = '0;
            @(negedge clk);
            chk($sformatf("v%0d_push", v), 128'(push), 128'(vecs[v].exp_push));
            chk($sformatf("v%0d_pop_in_push", v), 128'(pop), 128'd0);
            chk($sformatf("v%0d_dpush", v), 128'(D_push), {8{vecs[v].data}});
            @(negedge clk);
            chk($sformatf("v%0d_push_clr", v), 128'(push), 128'd0);
            chk($sformatf("v%0d_dpush_hold", v), 128'(D_push), {8{vecs[v].data}});
        end

        // Drivers 1 and 6 contend; first grant lands on the first edge after release.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pndng[0][1] = 1'b1;
        pndng[0][6] = 1'b1;
        D_pop[0][1] = 16'h0011;
        D_pop[0][6] = 16'h0322;
        reset = 1'b1;
        @(negedge clk);
        chk("arb_first_pop", 128'(pop), 128'(8'h02));
        @(negedge clk);
        chk("arb_first_push", 128'(push), 128'(8'h01));
        chk("arb_first_dpush", 128'(D_push), {8{16'h0011}});
        D_pop[0][1] = 16'h0033;
        @(negedge clk);
        chk("arb_idle_pop", 128'(pop), 128'd0);
        @(negedge clk);
        chk("arb_second_pop", 128'(pop), 128'(8'h40));
        @(negedge clk);
        chk("arb_second_push", 128'(push), 128'(8'h08));
        chk("arb_second_dpush", 128'(D_push), {8{16'h0322}});
        pndng[0][6] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arb_third_pop", 128'(pop), 128'(8'h02));
        pndng = '0;
        @(negedge clk);
        chk("arb_third_push", 128'(push), 128'(8'h01));
        chk("arb_third_dpush", 128'(D_push), {8{16'h0033}});
        @(negedge clk);

        // Reset pulled mid-POP must clear strobes without waiting for a clock edge.
        pndng[0][2] = 1'b1;
        D_pop[0][2] = 16'h05AB;
        @(posedge clk);
        #1;
        chk("rst_pop_before", 128'(pop), 128'(8'h04));
        #1;
        reset = 1'b0;
        #1;
        chk("rst_pop_async", 128'(pop), 128'd0);
        chk("rst_push_async", 128'(push), 128'd0);
        chk("rst_dpush_async", 128'(D_push), 128'd0);
        pndng = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst_no_stale_push%0d", c), 128'(push), 128'd0);
            chk($sformatf("rst_no_stale_pop%0d", c), 128'(pop), 128'd0);
        end

        // Reset clears last_grant, so driver 0 beats driver 5 again.
        do_reset();
        pndng[0][0] = 1'b1;
        pndng[0][5] = 1'b1;
        D_pop[0][0] = 16'h0101;
        D_pop[0][5] = 16'h0202;
        @(negedge clk);
        chk("post_rst_prio_pop", 128'(pop), 128'(8'h01));
        pndng = '0;
        @(negedge clk);
        chk("post_rst_prio_push", 128'(push), 128'(8'h02));
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bs_gnrtr_n_rbtr.md
BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 Parameter bits, default 1: number of bus instances; only bits=1 is required; the outer array index is 0.
REQ-002 Parameter drvrs, default 4: number of attached drivers, range 2..16.
REQ-003 Parameter pckg_sz, default 16: packet width in bits, minimum 9.
REQ-004 Parameter broadcast, default 8'hFF: destination ID meaning "all drivers".
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: reset, asynchronous, active-low.
REQ-007 Port pndng, input, [bits-1:0][drvrs-1:0]: driver d's FIFO is non-empty.
REQ-008 Port D_pop, input, [bits-1:0][drvrs-1:0][pckg_sz-1:0]: head-of-FIFO packet of driver d; valid while pndng[0][d]=1.
REQ-009 Port pop, output, [bits-1:0][drvrs-1:0]: one-cycle pop strobe to driver d.
REQ-010 Port push, output, [bits-1:0][drvrs-1:0]: one-cycle push strobe into driver d's receive FIFO.
REQ-011 Port D_push, output, [bits-1:0][drvrs-1:0][pckg_sz-1:0]: shared bus data, same value to every driver.

Function
REQ-012 Packet format: bits [pckg_sz-1:pckg_sz-8] = destination ID; the remaining bits = payload, carried unmodified.
REQ-013 FSM states IDLE, POP, PUSH; one transfer in flight at a time.
REQ-014 IDLE: if any pndng bit is 1, the block latches the round-robin grant and moves to POP; otherwise it stays in IDLE.
REQ-015 Round-robin: search starts at (last_grant+1) mod drvrs, wrapping; last_grant resets to drvrs-1, so driver 0 has first priority.
REQ-016 POP (one cycle): pop[0][grant]=1 and all other pop bits are 0; D_pop[0][grant] is captured into a packet register at the end of the cycle; next state PUSH.
REQ-017 PUSH (one cycle): D_push[0][*] = packet register; next state IDLE.
REQ-018 Unicast, ID < drvrs: push[0][ID]=1 only, including ID equal to the source.
REQ-019 Broadcast, ID == broadcast: push=1 for every driver except the source.
REQ-020 Invalid ID (not broadcast and >= drvrs): no push bit is asserted; the packet is dropped silently.
REQ-021 Latency: grant in cycle N, pop in cycle N+1, push in cycle N+2; peak throughput 1 packet per 3 cycles.
REQ-022 pndng deasserting after grant does not abort the transfer.
REQ-023 pop and push are never asserted in the same cycle; at most one pop bit is set at any time.
REQ-024 D_push holds its last value outside PUSH.

Reset
REQ-025 While reset=0: state=IDLE, pop=0, push=0, D_push=0, packet register=0, last_grant=drvrs-1.
REQ-026 Reset asserted mid-transfer aborts it immediately; no pop or push for that packet occurs after release.
REQ-027 After reset deasserts, the first grant is evaluated on the first rising clk edge.

Structure
REQ-028 Shared package bus_pkg holds: ID_W=8, default broadcast 8'hFF, FSM state enum {IDLE, POP, PUSH}.
REQ-029 One sub-module rr_arbiter (parameter drvrs): inputs req, last_grant; output one-hot/index grant, combinational.
REQ-030 Target size: 120-400 lines of RTL; no memories; all outputs registered.

Verification (drvrs=8, pckg_sz=16)
REQ-031 Unicast: driver 2 pndng with D_pop=16'h05AB -> pop[0][2] one cycle; two cycles after grant, push[0][5]=1 only, D_push=16'h05AB.
REQ-032 Broadcast: driver 0 sends 16'hFF12 -> push[0][7:1]=7'h7F, push[0][0]=0, D_push=16'hFF12.
REQ-033 Invalid destination: driver 3 sends 16'h0A34 -> pop[0][3] pulses; push stays 0.
REQ-034 Arbitration: drivers 1 and 6 pending after reset -> driver 1 is served first, then driver 6; with driver 1 pending again, driver 6 is served before driver 1's second packet.
REQ-035 Reset: assert reset during POP -> pop and push drop to 0 asynchronously; after release, no stale push occurs.
